// File: rtl/data_ram_if.sv
// AXI4-Lite bundle between the load/store unit and the data RAM.
// 32-bit data, 4-bit byte strobes, one address space for loads and stores.
interface axi;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awprot, awvalid,
        output wdata, wstrb, wvalid,
        output bready,
        output araddr, arprot, arvalid,
        output rready,
        input  awready, wready,
        input  bresp, bvalid,
        input  arready,
        input  rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid,
        input  wdata, wstrb, wvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        input  rready,
        output awready, wready,
        output bresp, bvalid,
        output arready,
        output rdata, rresp, rvalid
    );
endinterface

// File: rtl/data_ram.sv
// AXI4-Lite slave word RAM with byte strobes; independent read and
// write channels, each with a single outstanding transaction.
module data_ram #(
    parameter int    ADDR_WIDTH = 10,
    parameter string INIT_FILE  = ""
) (
    input logic clk,
    input logic resetn,
    axi.slave   data
);
    localparam int IW    = ADDR_WIDTH - 2;
    localparam int DEPTH = 2 ** IW;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ADDR,
        W_DATA,
        W_RESP
    } wstate_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rstate_t;

    logic [31:0] mem [DEPTH];

    function automatic logic oor(input logic [31:0] a);
        return (a >> ADDR_WIDTH) != 32'd0;
    endfunction

    function automatic logic [IW-1:0] idx(input logic [31:0] a);
        return a[ADDR_WIDTH-1:2];
    endfunction

    wstate_t     wstate;
    rstate_t     rstate;
    logic [31:0] aw_addr_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;

    logic        aw_hs;
    logic        w_hs;
    logic        ar_hs;
    logic        cmt;
    logic [31:0] cmt_addr;
    logic [31:0] cmt_data;
    logic [3:0]  cmt_strb;

    logic unused_prot;
    assign unused_prot = ^{data.awprot, data.arprot};

    assign aw_hs = data.awvalid & data.awready;
    assign w_hs  = data.wvalid & data.wready;
    assign ar_hs = data.arvalid & data.arready;

    always_comb begin
        cmt      = 1'b0;
        cmt_addr = aw_addr_q;
        cmt_data = w_data_q;
        cmt_strb = w_strb_q;
        unique case (wstate)
            W_IDLE: begin
                cmt      = aw_hs & w_hs;
                cmt_addr = data.awaddr;
                cmt_data = data.wdata;
                cmt_strb = data.wstrb;
            end
            W_DATA: begin
                cmt      = w_hs;
                cmt_data = data.wdata;
                cmt_strb = data.wstrb;
            end
            W_ADDR: begin
                cmt      = aw_hs;
                cmt_addr = data.awaddr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wstate       <= W_IDLE;
            data.awready <= 1'b0;
            data.wready  <= 1'b0;
            data.bvalid  <= 1'b0;
            data.bresp   <= 2'b00;
            aw_addr_q    <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
        end else begin
            unique case (wstate)
                W_IDLE: begin
                    if (cmt) begin
                        wstate       <= W_RESP;
                        data.awready <= 1'b0;
                        data.wready  <= 1'b0;
                        data.bvalid  <= 1'b1;
                        data.bresp   <= oor(cmt_addr) ? 2'b10 : 2'b00;
                    end else if (aw_hs) begin
                        aw_addr_q    <= data.awaddr;
                        wstate       <= W_DATA;
                        data.awready <= 1'b0;
                        data.wready  <= 1'b1;
                    end else if (w_hs) begin
                        w_data_q     <= data.wdata;
                        w_strb_q     <= data.wstrb;
                        wstate       <= W_ADDR;
                        data.awready <= 1'b1;
                        data.wready  <= 1'b0;
                    end else begin
                        data.awready <= 1'b1;
                        data.wready  <= 1'b1;
                    end
                end
                W_DATA, W_ADDR: begin
                    if (cmt) begin
                        wstate       <= W_RESP;
                        data.awready <= 1'b0;
                        data.wready  <= 1'b0;
                        data.bvalid  <= 1'b1;
                        data.bresp   <= oor(cmt_addr) ? 2'b10 : 2'b00;
                    end
                end
                W_RESP: begin
                    if (data.bready) begin
                        wstate       <= W_IDLE;
                        data.bvalid  <= 1'b0;
                        data.awready <= 1'b1;
                        data.wready  <= 1'b1;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && cmt && !oor(cmt_addr)) begin
            for (int i = 0; i < 4; i++) begin
                if (cmt_strb[i]) begin
                    mem[idx(cmt_addr)][8*i +: 8] <= cmt_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rstate       <= R_IDLE;
            data.arready <= 1'b0;
            data.rvalid  <= 1'b0;
            data.rresp   <= 2'b00;
            data.rdata   <= '0;
        end else begin
            unique case (rstate)
                R_IDLE: begin
                    if (ar_hs) begin
                        rstate       <= R_RESP;
                        data.arready <= 1'b0;
                        data.rvalid  <= 1'b1;
                        if (oor(data.araddr)) begin
                            data.rdata <= '0;
                            data.rresp <= 2'b10;
                        end else begin
                            data.rdata <= mem[idx(data.araddr)];
                            data.rresp <= 2'b00;
                        end
                    end else begin
                        data.arready <= 1'b1;
                    end
                end
                R_RESP: begin
                    if (data.rready) begin
                        rstate       <= R_IDLE;
                        data.rvalid  <= 1'b0;
                        data.arready <= 1'b1;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_ram.sv
// Bench for data_ram: vector table, directed corner sequences and
// random traffic checked against an array model of the memory.
module tb_data_ram;
    logic clk;
    logic resetn;
    axi   bus ();

    data_ram #(.ADDR_WIDTH(10), .INIT_FILE("")) dut (
        .clk    (clk),
        .resetn (resetn),
        .data   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          wr;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [1:0]  bresp;
        logic [31:0] raddr;
        logic [31:0] rdata;
        logic [1:0]  rresp;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] model [256];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // mode 0: AW and W together, 1: AW first, 2: W first
    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int mode, input int bdly,
                      output logic [1:0] resp);
        int n;
        bit ah, wh, ad, wd;
        n  = 0;
        ad = 0;
        wd = 0;
        bus.awaddr = a;
        bus.wdata  = d;
        bus.wstrb  = s;
        bus.bready = 1'b0;
        bus.awvalid = (mode != 2);
        bus.wvalid  = (mode != 1);
        while (!(ad && wd) && n < 50) begin
            ah = bus.awvalid && bus.awready;
            wh = bus.wvalid && bus.wready;
            tick();
            n++;
            if (ah) begin bus.awvalid = 1'b0; ad = 1; end
            if (wh) begin bus.wvalid = 1'b0; wd = 1; end
            if (ad && !wd) bus.wvalid = 1'b1;
            if (wd && !ad) bus.awvalid = 1'b1;
        end
        repeat (bdly) tick();
        while (!bus.bvalid && n < 50) begin tick(); n++; end
        chk("wr_done", 32'(n < 50), 32'd1);
        resp = bus.bresp;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b1;
        tick();
        bus.bready  = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input int rdly,
                      output logic [31:0] d, output logic [1:0] resp);
        int n;
        bit h;
        n = 0;
        h = 0;
        bus.araddr  = a;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b0;
        while (!h && n < 50) begin
            h = bus.arready;
            tick();
            n++;
        end
        bus.arvalid = 1'b0;
        repeat (rdly) tick();
        while (!bus.rvalid && n < 50) begin tick(); n++; end
        chk("rd_done", 32'(n < 50), 32'd1);
        d    = bus.rdata;
        resp = bus.rresp;
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
    endtask

    logic [31:0] rdat;
    logic [1:0]  rsp;

    initial begin
        resetn      = 1'b0;
        bus.awaddr  = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata   = '0; bus.wstrb  = '0; bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;
        bus.araddr  = '0; bus.arprot = '0; bus.arvalid = 1'b0;
        bus.rready  = 1'b0;

        // Reset
        repeat (3) tick();
        chk("rst_awready", 32'(bus.awready), 0);
        chk("rst_wready",  32'(bus.wready),  0);
        chk("rst_arready", 32'(bus.arready), 0);
        chk("rst_bvalid",  32'(bus.bvalid),  0);
        chk("rst_rvalid",  32'(bus.rvalid),  0);
        chk("rst_rdata",   bus.rdata, 0);
        resetn = 1'b1;
        tick();
        chk("rel_awready", 32'(bus.awready), 1);
        chk("rel_wready",  32'(bus.wready),  1);
        chk("rel_arready", 32'(bus.arready), 1);

        // Full word with exact latency
        bus.awaddr = 32'h004; bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        chk("lat_bvalid", 32'(bus.bvalid), 1);
        chk("lat_bresp",  32'(bus.bresp), 0);
        chk("lat_awready_busy", 32'(bus.awready), 0);
        tick();
        bus.bready = 1'b0;
        chk("lat_bvalid_drop", 32'(bus.bvalid), 0);
        chk("lat_awready_back", 32'(bus.awready), 1);
        bus.araddr = 32'h004; bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        chk("lat_rvalid", 32'(bus.rvalid), 1);
        chk("lat_rdata",  bus.rdata, 32'hDEADBEEF);
        chk("lat_rresp",  32'(bus.rresp), 0);
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        chk("lat_rvalid_drop", 32'(bus.rvalid), 0);

        // Vector table
        tbl.push_back('{1, 32'h000, 32'hCAFEF00D, 4'hF, 2'b00, 32'h000, 32'hCAFEF00D, 2'b00});
        tbl.push_back('{1, 32'h008, 32'h11223344, 4'hF, 2'b00, 32'h008, 32'h11223344, 2'b00});
        tbl.push_back('{1, 32'h008, 32'h0000AA00, 4'h2, 2'b00, 32'h008, 32'h1122AA44, 2'b00});
        tbl.push_back('{1, 32'h008, 32'hBBBB0000, 4'hC, 2'b00, 32'h008, 32'hBBBBAA44, 2'b00});
        tbl.push_back('{1, 32'h008, 32'hFFFFFFFF, 4'h0, 2'b00, 32'h008, 32'hBBBBAA44, 2'b00});
        tbl.push_back('{1, 32'h400, 32'h12345678, 4'hF, 2'b10, 32'h000, 32'hCAFEF00D, 2'b00});
        tbl.push_back('{0, 32'h000, 32'h0,        4'h0, 2'b00, 32'h400, 32'h0,        2'b10});
        tbl.push_back('{1, 32'h3FF, 32'h0BADCAFE, 4'hF, 2'b00, 32'h3FC, 32'h0BADCAFE, 2'b00});
        tbl.push_back('{1, 32'h80000000, 32'h1,   4'hF, 2'b10, 32'h3FC, 32'h0BADCAFE, 2'b00});
        tbl.push_back('{1, 32'h006, 32'h00A50000, 4'h4, 2'b00, 32'h004, 32'hDEA5BEEF, 2'b00});
        foreach (tbl[i]) begin
            if (tbl[i].wr) begin
                wr(tbl[i].waddr, tbl[i].wdata, tbl[i].strb, 0, 0, rsp);
                chk($sformatf("tbl%0d_bresp", i), 32'(rsp), 32'(tbl[i].bresp));
            end
            rd(tbl[i].raddr, 0, rdat, rsp);
            chk($sformatf("tbl%0d_rdata", i), rdat, tbl[i].rdata);
            chk($sformatf("tbl%0d_rresp", i), 32'(rsp), 32'(tbl[i].rresp));
        end

        // Split channels, AW first
        bus.awaddr = 32'h00C; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("awf_awready", 32'(bus.awready), 0);
            chk("awf_wready",  32'(bus.wready),  1);
            if (c == 2) begin
                bus.wdata = 32'h55; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
            end
            tick();
        end
        bus.wvalid = 1'b0;
        chk("awf_bvalid", 32'(bus.bvalid), 1);
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        rd(32'h00C, 0, rdat, rsp);
        chk("awf_rdata", rdat, 32'h55);

        // Split channels, W first
        wr(32'h00C, 32'h0, 4'hF, 0, 0, rsp);
        bus.wdata = 32'h55; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("wf_awready", 32'(bus.awready), 1);
            chk("wf_wready",  32'(bus.wready),  0);
            if (c == 2) begin
                bus.awaddr = 32'h00C; bus.awvalid = 1'b1;
            end
            tick();
        end
        bus.awvalid = 1'b0;
        chk("wf_bvalid", 32'(bus.bvalid), 1);
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        rd(32'h00C, 0, rdat, rsp);
        chk("wf_rdata", rdat, 32'h55);

        // Write response backpressure with a competing write offered
        wr(32'h014, 32'h77, 4'hF, 0, 0, rsp);
        bus.awaddr = 32'h018; bus.wdata = 32'h99; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        tick();
        bus.awaddr = 32'h014; bus.wdata = 32'hEE;
        repeat (5) begin
            chk("bp_bvalid",  32'(bus.bvalid),  1);
            chk("bp_bresp",   32'(bus.bresp),   0);
            chk("bp_awready", 32'(bus.awready), 0);
            chk("bp_wready",  32'(bus.wready),  0);
            tick();
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        rd(32'h014, 0, rdat, rsp);
        chk("bp_no_commit", rdat, 32'h77);

        // Read response backpressure with a competing read offered
        bus.araddr = 32'h018; bus.arvalid = 1'b1;
        tick();
        bus.araddr = 32'h014;
        repeat (5) begin
            chk("rbp_rvalid",  32'(bus.rvalid),  1);
            chk("rbp_rdata",   bus.rdata, 32'h99);
            chk("rbp_arready", 32'(bus.arready), 0);
            tick();
        end
        bus.arvalid = 1'b0; bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;

        // Same-edge read and write of one word
        wr(32'h010, 32'h1, 4'hF, 0, 0, rsp);
        bus.awaddr = 32'h010; bus.wdata = 32'h2; bus.wstrb = 4'hF;
        bus.araddr = 32'h010;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        chk("col_rvalid", 32'(bus.rvalid), 1);
        chk("col_bvalid", 32'(bus.bvalid), 1);
        chk("col_rdata",  bus.rdata, 32'h1);
        bus.bready = 1'b1; bus.rready = 1'b1;
        tick();
        bus.bready = 1'b0; bus.rready = 1'b0;
        rd(32'h010, 0, rdat, rsp);
        chk("col_after", rdat, 32'h2);

        // Random traffic against the array model
        for (int w = 32; w < 64; w++) begin
            model[w] = $urandom;
            wr(32'(w * 4), model[w], 4'hF, 0, 0, rsp);
        end
        for (int it = 0; it < 300; it++) begin
            int          w;
            bit          bad;
            logic [31:0] a, d;
            logic [3:0]  s;
            w   = int'($urandom_range(32, 63));
            a   = 32'(w * 4) + 32'($urandom_range(0, 3));
            bad = ($urandom_range(0, 9) == 0);
            if (bad) a = a | (32'h400 << $urandom_range(0, 21));
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom);
                wr(a, d, s, int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 3)), rsp);
                chk("rnd_bresp", 32'(rsp), bad ? 32'd2 : 32'd0);
                if (!bad) begin
                    for (int b = 0; b < 4; b++)
                        if (s[b]) model[w][8*b +: 8] = d[8*b +: 8];
                end
            end else begin
                rd(a, int'($urandom_range(0, 3)), rdat, rsp);
                chk("rnd_rdata", rdat, bad ? 32'd0 : model[w]);
                chk("rnd_rresp", 32'(rsp), bad ? 32'd2 : 32'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
